// File: rtl/vector_normalize_pipe.sv
// Pipelined fixed-point vector normaliser: greedy MSB-first search for the largest
// scale s with |v*s|^2 <= 1.0, one scale bit per stage, valid/ready with global stall.
module vector_normalize_pipe #(
   parameter int W = 16,
   parameter int F = 8,
   parameter int N = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_vec,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] out_vec,
   output logic [W-2:0]   out_scale,
   output logic           out_zero
);

   localparam int S    = W - 1;
   localparam int SUMW = 2 * W + $clog2(N + 1);

   typedef logic signed [2*W-1:0] wide_t;

   function automatic wide_t comp_prod(input logic [W-1:0] v, input logic [W-2:0] c);
      wide_t a;
      wide_t b;
      wide_t prod;
      a    = wide_t'($signed(v));
      b    = wide_t'({1'b0, c});
      prod = a * b;
      return prod >>> F;
   endfunction

   // Squares use the truncated product; any truncation is already an overflow reject.
   // Since 2^F < 2^(W-1)-1, the unit-length bound also covers dot overflow.
   function automatic logic trial_ok(input logic [N*W-1:0] vec, input logic [W-2:0] c);
      wide_t             p;
      logic signed [W-1:0] pw;
      wide_t             sq;
      logic [SUMW-1:0]   acc;
      logic              ovf;
      acc = '0;
      ovf = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         p = comp_prod(vec[i*W +: W], c);
         if (p[2*W-1:W-1] != '0 && p[2*W-1:W-1] != '1) ovf = 1'b1;
         pw  = p[W-1:0];
         sq  = wide_t'(pw) * wide_t'(pw);
         acc = acc + SUMW'($unsigned(sq));
      end
      return !ovf && ((acc >> F) <= (SUMW'(1) << F));
   endfunction

   function automatic logic [W-2:0] search_step(input logic [N*W-1:0] vec,
                                                input logic [W-2:0] s,
                                                input int unsigned b);
      logic [W-2:0] c;
      c    = s;
      c[b] = 1'b1;
      return trial_ok(vec, c) ? c : s;
   endfunction

   function automatic logic [N*W-1:0] scale_vec(input logic [N*W-1:0] vec, input logic [W-2:0] s);
      wide_t          p;
      logic [N*W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < N; i++) begin
         p             = comp_prod(vec[i*W +: W], s);
         r[i*W +: W]   = p[W-1:0];
      end
      return r;
   endfunction

   logic           valid_q [S];
   logic           valid_d [S];
   logic [N*W-1:0] vec_q   [S];
   logic [N*W-1:0] vec_d   [S];
   logic [W-2:0]   s_q     [S];
   logic [W-2:0]   s_d     [S];
   logic           zero_q  [S];
   logic           zero_d  [S];

   logic           out_valid_q, out_valid_d;
   logic [N*W-1:0] out_vec_q,   out_vec_d;
   logic [W-2:0]   out_scale_q, out_scale_d;
   logic           out_zero_q,  out_zero_d;
   logic           advance;

   always_comb begin
      advance = !out_valid_q || out_ready;
      for (int unsigned k = 0; k < S; k++) begin
         valid_d[k] = valid_q[k];
         vec_d[k]   = vec_q[k];
         s_d[k]     = s_q[k];
         zero_d[k]  = zero_q[k];
      end
      out_valid_d = out_valid_q;
      out_vec_d   = out_vec_q;
      out_scale_d = out_scale_q;
      out_zero_d  = out_zero_q;
      if (advance) begin
         valid_d[0] = in_valid;
         vec_d[0]   = in_vec;
         zero_d[0]  = (in_vec == '0);
         s_d[0]     = search_step(in_vec, '0, W - 2);
         for (int unsigned k = 1; k < S; k++) begin
            valid_d[k] = valid_q[k-1];
            vec_d[k]   = vec_q[k-1];
            zero_d[k]  = zero_q[k-1];
            s_d[k]     = search_step(vec_q[k-1], s_q[k-1], W - 2 - k);
         end
         out_valid_d = valid_q[S-1];
         out_vec_d   = scale_vec(vec_q[S-1], s_q[S-1]);
         out_scale_d = s_q[S-1];
         out_zero_d  = zero_q[S-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < S; k++) begin
            valid_q[k] <= 1'b0;
            vec_q[k]   <= '0;
            s_q[k]     <= '0;
            zero_q[k]  <= 1'b0;
         end
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_scale_q <= '0;
         out_zero_q  <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < S; k++) begin
            valid_q[k] <= valid_d[k];
            vec_q[k]   <= vec_d[k];
            s_q[k]     <= s_d[k];
            zero_q[k]  <= zero_d[k];
         end
         out_valid_q <= out_valid_d;
         out_vec_q   <= out_vec_d;
         out_scale_q <= out_scale_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_scale = out_scale_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_vector_normalize_pipe.sv
// Directed and streaming checks for vector_normalize_pipe at (16,8,3) and (12,4,4).
module tb_vector_normalize_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [47:0] in_vec, out_vec;
   logic [14:0] out_scale;

   logic        in_valid2, in_ready2, out_valid2, out_ready2, out_zero2;
   logic [47:0] in_vec2, out_vec2;
   logic [10:0] out_scale2;

   vector_normalize_pipe #(.W(16), .F(8), .N(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
      .out_scale(out_scale), .out_zero(out_zero));

   vector_normalize_pipe #(.W(12), .F(4), .N(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_vec(in_vec2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_vec(out_vec2),
      .out_scale(out_scale2), .out_zero(out_zero2));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [47:0] pack3(input int a, input int b, input int c);
      return {16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [47:0] pack4(input int a, input int b, input int c, input int d);
      return {12'(d), 12'(c), 12'(b), 12'(a)};
   endfunction

   // Reference model straight from the trial definition, 64-bit arithmetic.
   function automatic bit mok(input int w, input int f, input int n, input longint v[4], input longint c);
      longint p, acc, d;
      bit     ovf;
      acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         p = (v[i] * c) >>> f;
         if (p > (longint'(1) << (w - 1)) - 1 || p < -(longint'(1) << (w - 1))) ovf = 1'b1;
         else acc += p * p;
      end
      d = acc >>> f;
      return !ovf && d <= (longint'(1) << (w - 1)) - 1 && d <= (longint'(1) << f);
   endfunction

   function automatic longint mscale(input int w, input int f, input int n, input longint v[4]);
      longint s;
      s = 0;
      for (int b = w - 2; b >= 0; b--)
         if (mok(w, f, n, v, s | (longint'(1) << b))) s = s | (longint'(1) << b);
      return s;
   endfunction

   function automatic longint mvec(input int w, input int f, input int n, input longint v[4], input longint s);
      longint r, mask;
      r    = 0;
      mask = (longint'(1) << w) - 1;
      for (int i = 0; i < n; i++) r = r | ((((v[i] * s) >>> f) & mask) << (i * w));
      return r;
   endfunction

   task automatic run1(input logic [47:0] v, input string tag, output int lat);
      @(negedge clk);
      in_vec   = v;
      in_valid = 1'b1;
      #1 chk({tag, " in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run2(input logic [47:0] v, input string tag, output int lat);
      @(negedge clk);
      in_vec2   = v;
      in_valid2 = 1'b1;
      #1 chk({tag, " in_ready2"}, in_ready2, 1);
      @(negedge clk);
      in_valid2 = 1'b0;
      lat       = 1;
      while (!out_valid2 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   typedef struct {
      int v0, v1, v2;
      int es;
      int e0, e1, e2;
      bit ez;
   } vrec_t;

   typedef struct {
      int v0, v1, v2, v3;
      int es;
      int e0, e1, e2, e3;
      bit ez;
   } vrec2_t;

   vrec_t  tbl  [5];
   vrec2_t tbl2 [3];

   logic [47:0] q_vec [$];
   logic [14:0] q_s   [$];
   bit          q_z   [$];
   logic [47:0] svec  [20];

   initial begin
      int          lat, lat2, sent, recv;
      bit          stalled;
      logic [47:0] h_vec, e_vec;
      logic [14:0] h_s, e_s;
      logic        h_z, e_z;
      longint      v[4];

      tbl[0] = '{768, 1024, 0, 51, 153, 204, 0, 0};
      tbl[1] = '{-768, -1024, 0, 51, -153, -204, 0, 0};
      tbl[2] = '{256, 0, 0, 256, 256, 0, 0, 0};
      tbl[3] = '{25600, 0, 0, 2, 200, 0, 0, 0};
      tbl[4] = '{0, 0, 0, 32767, 0, 0, 0, 1};
      tbl2[0] = '{48, 64, 0, 0, 3, 9, 12, 0, 0, 0};
      tbl2[1] = '{0, 0, 0, 16, 16, 0, 0, 0, 16, 0};
      tbl2[2] = '{0, 0, 0, 0, 2047, 0, 0, 0, 0, 1};

      rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
      in_valid2 = 1'b0; in_vec2 = '0; out_ready2 = 1'b1;

      #2;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_vec", out_vec, 0);
      chk("reset out_scale", out_scale, 0);
      chk("reset out_zero", out_zero, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid2", out_valid2, 0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 5; t++) begin
         run1(pack3(tbl[t].v0, tbl[t].v1, tbl[t].v2), $sformatf("vec%0d", t), lat);
         chk($sformatf("vec%0d latency", t), lat, 16);
         chk($sformatf("vec%0d out_scale", t), out_scale, tbl[t].es);
         chk($sformatf("vec%0d out_vec", t), out_vec, pack3(tbl[t].e0, tbl[t].e1, tbl[t].e2));
         chk($sformatf("vec%0d out_zero", t), out_zero, tbl[t].ez);
      end

      for (int t = 0; t < 3; t++) begin
         run2(pack4(tbl2[t].v0, tbl2[t].v1, tbl2[t].v2, tbl2[t].v3), $sformatf("p2vec%0d", t), lat);
         chk($sformatf("p2vec%0d latency", t), lat, 12);
         chk($sformatf("p2vec%0d out_scale", t), out_scale2, tbl2[t].es);
         chk($sformatf("p2vec%0d out_vec", t), out_vec2,
             pack4(tbl2[t].e0, tbl2[t].e1, tbl2[t].e2, tbl2[t].e3));
         chk($sformatf("p2vec%0d out_zero", t), out_zero2, tbl2[t].ez);
      end

      // Streaming with random backpressure against the reference model.
      for (int i = 0; i < 20; i++)
         svec[i] = pack3(int'($urandom_range(0, 6000)) - 3000, int'($urandom_range(0, 6000)) - 3000,
                         int'($urandom_range(0, 600)) - 300);
      svec[7]  = '0;
      svec[13] = pack3(25600, -100, 7);
      sent = 0; recv = 0; stalled = 1'b0;
      h_vec = '0; h_s = '0; h_z = 1'b0;
      for (int cyc = 0; cyc < 600 && recv < 20; cyc++) begin
         @(negedge clk);
         if (stalled) begin
            chk("hold out_vec", out_vec, h_vec);
            chk("hold out_scale", out_scale, h_s);
            chk("hold out_zero", out_zero, h_z);
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 20);
         if (sent < 20) in_vec = svec[sent];
         #1;
         chk("in_ready rule", in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            if (q_s.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stream extra output: got scale %0d expected none", out_scale);
            end else begin
               e_vec = q_vec.pop_front();
               e_s   = q_s.pop_front();
               e_z   = q_z.pop_front();
               chk($sformatf("stream%0d out_vec", recv), out_vec, e_vec);
               chk($sformatf("stream%0d out_scale", recv), out_scale, e_s);
               chk($sformatf("stream%0d out_zero", recv), out_zero, e_z);
            end
            recv++;
         end
         stalled = out_valid && !out_ready;
         h_vec = out_vec; h_s = out_scale; h_z = out_zero;
         if (in_valid && in_ready) begin
            v = '{longint'($signed(in_vec[15:0])), longint'($signed(in_vec[31:16])),
                  longint'($signed(in_vec[47:32])), 0};
            e_s = 15'(mscale(16, 8, 3, v));
            q_s.push_back(e_s);
            q_vec.push_back(48'(mvec(16, 8, 3, v, longint'(e_s))));
            q_z.push_back(in_vec == '0);
            sent++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("stream received", recv, 20);
      chk("stream leftover", q_s.size(), 0);

      // Reset with stalled, valid outputs and a partly filled pipeline.
      out_ready = 1'b0; out_ready2 = 1'b0;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid  = 1'b1; in_vec  = pack3(1000 + i, -500, 2000);
         in_valid2 = 1'b1; in_vec2 = pack4(100 + i, -50, 20, 7);
      end
      @(negedge clk);
      in_valid = 1'b0; in_valid2 = 1'b0;
      repeat (18) @(negedge clk);
      chk("pre-reset out_valid", out_valid, 1);
      chk("pre-reset out_valid2", out_valid2, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out_valid", out_valid, 0);
      chk("async reset out_vec", out_vec, 0);
      chk("async reset out_scale", out_scale, 0);
      chk("async reset out_zero", out_zero, 0);
      chk("async reset in_ready", in_ready, 1);
      chk("async reset out_valid2", out_valid2, 0);
      chk("async reset out_vec2", out_vec2, 0);
      chk("async reset out_scale2", out_scale2, 0);
      chk("async reset in_ready2", in_ready2, 1);
      out_ready = 1'b1; out_ready2 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      fork
         run1(pack3(768, 1024, 0), "post-reset", lat);
         run2(pack4(48, 64, 0, 0), "post-reset p2", lat2);
      join
      chk("post-reset latency", lat, 16);
      chk("post-reset out_scale", out_scale, 51);
      chk("post-reset out_vec", out_vec, pack3(153, 204, 0));
      chk("post-reset latency p2", lat2, 12);
      chk("post-reset out_scale p2", out_scale2, 3);
      chk("post-reset out_vec p2", out_vec2, pack4(9, 12, 0, 0));
      repeat (20) begin
         @(negedge clk);
         chk("post-reset no stale", out_valid, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vector_normalize_pipe.md
# vector_normalize_pipe

Parametrised, flow-controlled successor to the fixed-point vector normaliser. It scales an N-component signed fixed-point vector toward unit length by finding the largest non-negative scalar `s`, one bit per pipeline stage, such that `|v*s|^2 <= 1.0`. It sits in the vector_math datapath between the vector producers (transform/lighting units) and consumers that need unit normals. It adds a valid/ready handshake with global stall, zero-vector detection, and scale-factor output.

## Interface
- `W`, default 16: total fixed-point width, signed two's complement.
- `F`, default 8: fraction bits. Constraint: 1 <= F <= W-2.
- `N`, default 3: vector component count. Constraint: N >= 1.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input vector present.
- `in_ready`  out  1  block accepts input this cycle.
- `in_vec`  in  N*W  components; component i at bits [i*W +: W].
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_vec`  out  N*W  normalised vector, same packing.
- `out_scale`  out  W-1  final scalar `s`, unsigned, F fraction bits.
- `out_zero`  out  1  input was the all-zero vector.

## Operation
- **Trial arithmetic** for candidate `c`:
  - Component product: `p_i = (v_i * c) >>> F`. Take the full-precision 2W-bit product, then arithmetic shift, which floors.
  - Product overflow: any `p_i` outside [-2^(W-1), 2^(W-1)-1].
  - Dot product: `d = (sum p_i^2) >>> F`, summed at full precision.
  - Dot overflow: `d > 2^(W-1)-1`.
  - Candidate accepted iff there is no product overflow, no dot overflow, and `d <= 2^F` (1.0).
- **Bit search**:
  - Stage k, for k = 0..W-2, tests bit `W-2-k`.
  - Candidate `c = s_k | (1 << (W-2-k))`.
  - `s_{k+1} = c` if accepted, else `s_k`. `s_0 = 0`.
  - The search is greedy MSB-first. It yields the maximal `s` because the acceptance test is monotonic in `s`.
- **Output stage**:
  - `out_vec_i = (v_i * s) >>> F` with the same truncation, where `s = s_{W-1}`.
  - `out_scale = s`.
  - `out_zero` = all input components equal 0.
  - For a zero vector, every candidate is accepted, so `s = 2^(W-1)-1` and `out_vec` = 0.
- **Accuracy**: large vectors give coarse `s` (few significant bits). This is accepted behaviour. Never flag it, never saturate.
- Each stage carries `{valid, vec, s_k, zero}` registers. The original `v` travels with the partial scalar.

## Timing
- **Pipeline**: W-1 search stages plus 1 output stage, W register stages in total. Latency is exactly W cycles from an accepted input to `out_valid` when there are no stalls.
- **Stall rule**:
  - `advance = !out_valid || out_ready`.
  - `in_ready = advance`, combinational.
  - When `advance = 0`, every stage register holds, including payload.
  - When `advance = 1`, every stage shifts by one.
- **Bubbles**: a stage with valid=0 still shifts, and its payload is don't-care. Bubbles are not collapsed.
- **Output hold**: `out_vec`, `out_scale` and `out_zero` stay stable while `out_valid && !out_ready`.
- **Transfer timing**: an input transfer occurs on a cycle with `in_valid && in_ready`. An output transfer occurs on a cycle with `out_valid && out_ready`. Both may happen in the same cycle.
- **Throughput**: one vector per cycle with `out_ready` held high.
- **Reset**: asynchronous assertion clears all stage valid bits and payload registers.
  - Outputs in reset: `out_valid` = 0, `out_vec` = 0, `out_scale` = 0, `out_zero` = 0.
  - `in_ready` = 1 during and after reset.
  - Reset mid-operation discards all in-flight vectors. There is no partial output.
  - Deassertion is synchronised externally. The first accept can occur on the first rising edge after deassertion.

## Test plan
All scenarios use W=16, F=8, N=3 unless stated.
- **Pythagorean**: in `(3.0, 4.0, 0)` = (768, 1024, 0) -> after 16 cycles, `out_scale` = 51, `out_vec` = (153, 204, 0), `out_zero` = 0. Also check that candidate 52 was rejected: d = 264 > 256.
- **Sign and unit**:
  - `(-3.0, -4.0, 0)` -> `out_vec` = (-153, -204, 0), `out_scale` = 51.
  - `(1.0, 0, 0)` -> `out_scale` = 256, `out_vec` = (256, 0, 0).
- **Large vector and overflow rejection**: `(100.0, 0, 0)` = 25600 -> `out_scale` = 2, `out_vec` = (200, 0, 0). High candidates must be rejected via product overflow, not wrap.
- **Zero vector**: (0, 0, 0) -> `out_scale` = 32767, `out_vec` = 0, `out_zero` = 1.
- **Streaming and backpressure**:
  - Feed 20 back-to-back vectors with random `out_ready` (~50%).
  - Every output must match the golden model, in order, with no loss or duplication.
  - `in_ready` must equal `!out_valid || out_ready` every cycle.
  - Outputs must stay stable while stalled.
- **Reset mid-flight**:
  - Load 5 vectors, then assert `rst_n`=0 asynchronously between edges.
  - Immediately: `out_valid` = 0 and all outputs are 0.
  - After release, no stale vector appears, and a new input emerges exactly 16 cycles after acceptance.
  - Repeat with W=12, F=4, N=4 to check parametrisation.
